// File: rtl/regfile_pkg.sv
// Shared constants, index type and read-mux priority select for the multi-port register file.
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 6;

    typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 6'd0;

    typedef enum logic [1:0] {
        SEL_REG  = 2'd0,
        SEL_W0   = 2'd1,
        SEL_W1   = 2'd2,
        SEL_ZERO = 2'd3
    } rd_sel_e;

    // Hits are already qualified by write enable and bypass enable; the load port outranks ALU.
    function automatic rd_sel_e rd_sel(input logic is_zero, input logic hit1, input logic hit0);
        rd_sel_e sel;
        if (is_zero) begin
            sel = SEL_ZERO;
        end else if (hit1) begin
            sel = SEL_W1;
        end else if (hit0) begin
            sel = SEL_W0;
        end else begin
            sel = SEL_REG;
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register plus a registered population count.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     we0_i,
    input  logic [ADDR_W-1:0]        waddr0_i,
    input  logic                     we1_i,
    input  logic [ADDR_W-1:0]        waddr1_i,
    input  logic                     resv_i,
    input  logic [ADDR_W-1:0]        resv_addr_i,
    output logic [(2**ADDR_W)-1:0]   pend_o,
    output logic [ADDR_W:0]          busy_cnt_o
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic [ADDR_W:0]  cnt_q;
    logic [ADDR_W:0]  cnt_d;

    // Reserve outranks write-back: a newer producer keeps the register pending.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < DEPTH; i++) begin
            if ((ZERO_REG == 1'b1) && (i == 0)) begin
                pend_d[i] = 1'b0;
            end else if (resv_i && (resv_addr_i == ADDR_W'(i))) begin
                pend_d[i] = 1'b1;
            end else if ((we0_i && (waddr0_i == ADDR_W'(i))) ||
                         (we1_i && (waddr1_i == ADDR_W'(i)))) begin
                pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = pend_q[i];
            end
        end
    end

    // Count is taken from the next-state bits so it moves in the same cycle as they do.
    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + (ADDR_W+1)'(pend_d[i]);
        end
    end

    // Pending bits and count registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend_o     = pend_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports, NRD combinational read ports with optional
// write-through bypass, and a pending-write scoreboard for decode stalls.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int NRD      = 2,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic                    in_clk,
    input  logic                    in_rst_n,
    input  logic [NRD*ADDR_W-1:0]   in_raddr,
    output logic [NRD*DATA_W-1:0]   out_rdata,
    output logic [NRD-1:0]          out_rbusy,
    input  logic                    in_ctrl_regwrt0,
    input  logic [ADDR_W-1:0]       in_waddr0,
    input  logic [DATA_W-1:0]       in_wdata0,
    input  logic                    in_ctrl_regwrt1,
    input  logic [ADDR_W-1:0]       in_waddr1,
    input  logic [DATA_W-1:0]       in_wdata1,
    input  logic                    in_ctrl_resv,
    input  logic [ADDR_W-1:0]       in_resv_addr,
    output logic [ADDR_W:0]         out_busy_cnt
);

    localparam int DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic              wr0_ok_s;
    logic              wr1_ok_s;
    logic [DEPTH-1:0]  pend_s;

    assign wr0_ok_s = in_ctrl_regwrt0 && !((ZERO_REG == 1'b1) && (in_waddr0 == ZERO_IDX));
    assign wr1_ok_s = in_ctrl_regwrt1 && !((ZERO_REG == 1'b1) && (in_waddr1 == ZERO_IDX));

    // Port 1 is applied last so the load return wins a same-address collision.
    always_comb begin
        mem_d = mem_q;
        if (wr0_ok_s) begin
            mem_d[in_waddr0] = in_wdata0;
        end else begin
            mem_d[in_waddr0] = mem_q[in_waddr0];
        end
        if (wr1_ok_s) begin
            mem_d[in_waddr1] = in_wdata1;
        end else begin
            mem_d[in_waddr1] = mem_d[in_waddr1];
        end
    end

    // Storage array.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_i       (in_clk),
        .rst_n_i     (in_rst_n),
        .we0_i       (wr0_ok_s),
        .waddr0_i    (in_waddr0),
        .we1_i       (wr1_ok_s),
        .waddr1_i    (in_waddr1),
        .resv_i      (in_ctrl_resv),
        .resv_addr_i (in_resv_addr),
        .pend_o      (pend_s),
        .busy_cnt_o  (out_busy_cnt)
    );

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra_s;
        logic              is_zero_s;
        logic              hit0_s;
        logic              hit1_s;
        logic              resv_hit_s;
        rd_sel_e           sel_s;
        logic [DATA_W-1:0] data_s;
        logic              busy_s;

        assign ra_s       = in_raddr[k*ADDR_W +: ADDR_W];
        assign is_zero_s  = (ZERO_REG == 1'b1) && (ra_s == ZERO_IDX);
        assign hit0_s     = (BYPASS == 1'b1) && wr0_ok_s && (in_waddr0 == ra_s);
        assign hit1_s     = (BYPASS == 1'b1) && wr1_ok_s && (in_waddr1 == ra_s);
        assign resv_hit_s = in_ctrl_resv && (in_resv_addr == ra_s);
        assign sel_s      = rd_sel(is_zero_s, hit1_s, hit0_s);

        // Read data mux.
        always_comb begin
            case (sel_s)
                SEL_ZERO: data_s = '0;
                SEL_W1:   data_s = in_wdata1;
                SEL_W0:   data_s = in_wdata0;
                SEL_REG:  data_s = mem_q[ra_s];
                default:  data_s = '0;
            endcase
        end

        // A forwarded write satisfies the reader unless a newer producer is issuing now.
        assign busy_s = !is_zero_s && pend_s[ra_s] && !((hit0_s || hit1_s) && !resv_hit_s);

        assign out_rdata[k*DATA_W +: DATA_W] = in_rst_n ? data_s : '0;
        assign out_rbusy[k]                  = in_rst_n && busy_s;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a bypassing and a non-bypassing instance share stimulus.
module tb_regfile_mp;

    localparam int DW    = 32;
    localparam int AW    = 6;
    localparam int NR    = 2;
    localparam int DEPTH = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [NR*AW-1:0]  raddr;
    logic              we0, we1, resv;
    logic [AW-1:0]     wa0, wa1, ra;
    logic [DW-1:0]     wd0, wd1;
    logic [NR*DW-1:0]  rdata_b, rdata_n;
    logic [NR-1:0]     rbusy_b, rbusy_n;
    logic [AW:0]       cnt_b, cnt_n;

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .in_clk(clk), .in_rst_n(rst_n), .in_raddr(raddr), .out_rdata(rdata_b), .out_rbusy(rbusy_b),
        .in_ctrl_regwrt0(we0), .in_waddr0(wa0), .in_wdata0(wd0),
        .in_ctrl_regwrt1(we1), .in_waddr1(wa1), .in_wdata1(wd1),
        .in_ctrl_resv(resv), .in_resv_addr(ra), .out_busy_cnt(cnt_b));

    regfile_mp #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_nb (
        .in_clk(clk), .in_rst_n(rst_n), .in_raddr(raddr), .out_rdata(rdata_n), .out_rbusy(rbusy_n),
        .in_ctrl_regwrt0(we0), .in_waddr0(wa0), .in_wdata0(wd0),
        .in_ctrl_regwrt1(we1), .in_waddr1(wa1), .in_wdata1(wd1),
        .in_ctrl_resv(resv), .in_resv_addr(ra), .out_busy_cnt(cnt_n));

    typedef struct packed {
        logic [NR*DW-1:0] rd_b;
        logic [NR*DW-1:0] rd_n;
        logic [NR-1:0]    bz_b;
        logic [NR-1:0]    bz_n;
        logic [AW:0]      cnt;
    } exp_t;

    exp_t          q[$];
    exp_t          mon_e;
    logic [DW-1:0] mem [DEPTH];
    bit            pend [DEPTH];
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            check("rdata_bypass",  64'(rdata_b), 64'(mon_e.rd_b));
            check("rdata_nobyp",   64'(rdata_n), 64'(mon_e.rd_n));
            check("rbusy_bypass",  64'(rbusy_b), 64'(mon_e.bz_b));
            check("rbusy_nobyp",   64'(rbusy_n), 64'(mon_e.bz_n));
            check("busy_cnt",      64'(cnt_b),   64'(mon_e.cnt));
            check("busy_cnt_nb",   64'(cnt_n),   64'(mon_e.cnt));
        end
    end

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]  = '0;
            pend[i] = 1'b0;
        end
    endtask

    // Push the expectation for the inputs now applied, then advance the model over the edge.
    task automatic step();
        exp_t e;
        int   a;
        int   c;
        bit   hit, rr;
        e = '0;
        if (rst_n) begin
            for (int k = 0; k < NR; k++) begin
                a = int'(raddr[k*AW +: AW]);
                hit = (a != 0) && ((we1 && int'(wa1) == a) || (we0 && int'(wa0) == a));
                rr  = resv && (int'(ra) == a);
                e.rd_n[k*DW +: DW] = (a == 0) ? 32'd0 : mem[a];
                if (a == 0)                       e.rd_b[k*DW +: DW] = 32'd0;
                else if (we1 && int'(wa1) == a)   e.rd_b[k*DW +: DW] = wd1;
                else if (we0 && int'(wa0) == a)   e.rd_b[k*DW +: DW] = wd0;
                else                              e.rd_b[k*DW +: DW] = mem[a];
                e.bz_n[k] = (a != 0) && pend[a];
                e.bz_b[k] = (a != 0) && pend[a] && !(hit && !rr);
            end
            c = 0;
            for (int i = 0; i < DEPTH; i++) c += int'(pend[i]);
            e.cnt = (AW+1)'(c);
        end
        q.push_back(e);
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                if (resv && int'(ra) == i) pend[i] = 1'b1;
                else if ((we0 && int'(wa0) == i) || (we1 && int'(wa1) == i)) pend[i] = 1'b0;
            end
            if (we0 && wa0 != 6'd0) mem[wa0] = wd0;
            if (we1 && wa1 != 6'd0) mem[wa1] = wd1;
        end
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; resv = 1'b0;
        wa0 = 6'd0; wa1 = 6'd0; ra = 6'd0;
        wd0 = 32'd0; wd1 = 32'd0;
    endtask

    task automatic rd(input int a0, input int a1);
        raddr = {AW'(a1), AW'(a0)};
    endtask

    function automatic int rnd_addr();
        if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 63));
        return int'($urandom_range(0, 7));
    endfunction

    initial begin
        rst_n = 1'b0;
        idle();
        rd(0, 0);
        model_clear();
        @(posedge clk); #1;
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            rd(i, DEPTH - 1 - i);
            step();
        end
        // reset asserted while a write of 0xDEAD to r5 is in flight
        we0 = 1'b1; wa0 = 6'd5; wd0 = 32'h0000_DEAD; rd(5, 5);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; idle(); step();
        step();
        // dual write, then read back
        we0 = 1'b1; wa0 = 6'd1; wd0 = 32'd12;
        we1 = 1'b1; wa1 = 6'd2; wd1 = 32'h20; rd(1, 2);
        step();
        idle(); rd(1, 2); step();
        we0 = 1'b1; wa0 = 6'd0; wd0 = 32'h0000_FFFF; rd(0, 0); step();
        idle(); step();
        // same-cycle bypass of r3
        we0 = 1'b1; wa0 = 6'd3; wd0 = 32'hAA; rd(3, 3); step();
        idle(); step();
        // both ports hit r7
        we0 = 1'b1; wa0 = 6'd7; wd0 = 32'h11;
        we1 = 1'b1; wa1 = 6'd7; wd1 = 32'h22; rd(7, 7); step();
        idle(); step();
        // reserve r4, clear it with a load return
        resv = 1'b1; ra = 6'd4; rd(4, 0); step();
        idle(); step();
        we1 = 1'b1; wa1 = 6'd4; wd1 = 32'h55; step();
        idle(); step();
        // reserve and write r6 together, then a duplicate reserve
        resv = 1'b1; ra = 6'd6; rd(6, 6); step();
        resv = 1'b1; ra = 6'd6; we0 = 1'b1; wa0 = 6'd6; wd0 = 32'h66; step();
        idle(); step();
        resv = 1'b1; ra = 6'd6; step();
        idle(); step();
        // reserve of r0 is ignored
        resv = 1'b1; ra = 6'd0; rd(0, 6); step();
        idle(); step();
        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            rst_n = ($urandom_range(0, 149) != 0);
            we0  = $urandom_range(0, 1) == 1;
            we1  = $urandom_range(0, 2) == 0;
            resv = $urandom_range(0, 2) == 0;
            wa0  = AW'(rnd_addr());
            wa1  = ($urandom_range(0, 4) == 0) ? wa0 : AW'(rnd_addr());
            ra   = AW'(rnd_addr());
            wd0  = $urandom;
            wd1  = $urandom;
            rd(rnd_addr(), rnd_addr());
            if ($urandom_range(0, 5) == 0) raddr[2*AW-1:AW] = raddr[AW-1:0];
            step();
        end
        rst_n = 1'b1; idle(); step();
        repeat (3) @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file with write-through bypass and a pending-write scoreboard; replaces the fixed 64x32 single-write register file in the datapath.
- Writes are synchronous: one write port for the ALU/writeback stage and one for the memory/load return path.
- Reads are combinational on NRD read ports.
- The scoreboard flags registers whose producer has issued but not yet written back, so decode can stall.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 6, register index width; depth = 2**ADDR_W (default 64).
- NRD, 2, number of read ports (1..4).
- ZERO_REG, 1, 1 = register 0 always reads 0; writes and reserves to it are ignored.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports.

Ports:
- in_clk  input  1  clock, rising edge.
- in_rst_n  input  1  asynchronous active-low reset.
- in_raddr  input  NRD*ADDR_W  read addresses; port k is bits [k*ADDR_W +: ADDR_W].
- out_rdata  output  NRD*DATA_W  read data per port.
- out_rbusy  output  NRD  pending bit of the addressed register, per port.
- in_ctrl_regwrt0  input  1  write enable, port 0 (ALU writeback).
- in_waddr0  input  ADDR_W  write address, port 0.
- in_wdata0  input  DATA_W  write data, port 0.
- in_ctrl_regwrt1  input  1  write enable, port 1 (load return).
- in_waddr1  input  ADDR_W  write address, port 1.
- in_wdata1  input  DATA_W  write data, port 1.
- in_ctrl_resv  input  1  reserve (set pending) for in_resv_addr.
- in_resv_addr  input  ADDR_W  register being reserved by an issuing instruction.
- out_busy_cnt  output  ADDR_W+1  number of registers currently pending.

Behaviour:
- Reset: asynchronous and active-low. On assertion, all registers are 0, all pending bits are 0, out_busy_cnt = 0, and every out_rdata/out_rbusy = 0. Deassertion is synchronised externally. Reset mid-write discards the write.
- Write: on rising in_clk, if in_ctrl_regwrtN is set, reg[in_waddrN] <= in_wdataN. The new value is visible through storage from the next cycle.
- Dual write to the same address: port 1 (load) wins, and exactly one value is stored.
- ZERO_REG=1: writes to address 0 have no effect; reg 0 reads 0 and its busy bit reads 0 regardless of bypass or reserve.
- Read: combinational, zero latency. Priority order:
  - ZERO_REG and addr 0 -> 0.
  - Else BYPASS=1 and port 1 write hits -> in_wdata1.
  - Else BYPASS=1 and port 0 write hits -> in_wdata0.
  - Else reg[addr].
- BYPASS=0: reads always return the stored value; a same-cycle write is not forwarded.
- Pending bit per register, updated on rising in_clk:
  - set if in_ctrl_resv and in_resv_addr matches;
  - else cleared if any write port writes that address;
  - reserve and write to the same register in the same cycle -> the bit stays set (a newer producer is outstanding).
- out_rbusy[k]: combinational from the pending bit of in_raddr[k]. With BYPASS=1, a read whose address matches a same-cycle write reports busy 0 unless the pending bit is also being re-reserved this cycle.
- out_busy_cnt: registered population count of pending bits, updated in the same cycle as the bits. Range 0..2**ADDR_W with no wrap; a second reserve of an already-pending register does not increment it.
- Duplicate read addresses across ports are legal and return identical data.

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_W/ADDR_W constants;
  - the reg_idx_t typedef (ADDR_W bits);
  - the REG_ZERO constant;
  - a function computing the read-mux priority select.
- One sub-module, regfile_scoreboard: pending bits, set/clear priority, out_busy_cnt. regfile_mp instantiates it next to the storage array and the NRD bypass muxes.

Test Plan:
- Reset then read all 64 addresses on both ports -> all data 0, busy 0, out_busy_cnt 0. Assert in_rst_n low mid-write of 0xDEAD to r5 -> r5 reads 0 after release.
- Write r1=12 via port 0, r2=0x20 via port 1 in the same cycle; next cycle read r1/r2 -> 0x0000000C / 0x00000020. Write r0=0xFFFF -> r0 reads 0.
- Same-cycle write r3=0xAA on port 0 and read r3 with BYPASS=1 -> 0xAA in that cycle. With BYPASS=0 -> old value, then 0xAA the next cycle.
- Both ports write r7 (port 0 0x11, port 1 0x22) -> bypass read and stored value are both 0x22.
- Reserve r4 -> next cycle out_rbusy=1, cnt=1. Port 1 writes r4=0x55 -> busy 0 that cycle via bypass, bit clear next cycle, cnt=0.
- Reserve r6 and write r6 in the same cycle -> r6 pending stays 1, cnt unchanged at 1. Reserve r6 again -> cnt stays 1.
